// File: rtl/safe_wrapper_csr.sv
// Safe-CPU mode sequencer: a CSR slave that halts all harts, commits the selected lockstep mode and resumes them.
// Optional WAIT_HALT abort counter is enabled by defining SAFE_CSR_TIMEOUT_EN.
package safe_wrapper_csr_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module safe_wrapper_csr #(
    parameter int  NHARTS         = 3,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter type reg_req_t      = safe_wrapper_csr_pkg::reg_req_t,
    parameter type reg_rsp_t      = safe_wrapper_csr_pkg::reg_rsp_t
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  reg_req_t          reg_req_i,
    output reg_rsp_t          reg_rsp_o,
    input  logic [NHARTS-1:0] halted_i,
    output logic [NHARTS-1:0] debug_req_o,
    output logic              resume_o,
    output logic [1:0]        active_mode_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, HALT_REQ, WAIT_HALT, SWITCH, RESUME} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  mode_reg;
    logic [1:0]  active_mode_reg;
    logic [15:0] switch_cnt_reg;
    logic        done_reg;
    logic        timeout_flag;

    logic [2:0]  idx;
    logic        wr, busy, halt_req, do_switch, do_timeout;
    logic        mode_we, start, clr_done;
    logic        err;
    logic [31:0] rdata, status_word;

    assign idx  = reg_req_i.addr[4:2];
    assign wr   = reg_req_i.valid & reg_req_i.write;
    assign busy = (state_reg != IDLE);

    assign mode_we  = wr && idx == 3'd0 && reg_req_i.wdata[1:0] != 2'd3 && !busy;
    assign start    = wr && idx == 3'd1 && reg_req_i.wdata[0];
    assign clr_done = wr && idx == 3'd2 && reg_req_i.wdata[1];

    // Address bits above the 5-bit window alias; wstrb is not honoured.
    logic unused_bits;
    assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0], reg_req_i.wstrb,
                           reg_req_i.wdata[31:2]};

    always_comb begin
        status_word = '0;
        status_word[0] = busy;
        status_word[1] = done_reg;
        status_word[2] = timeout_flag;
        status_word[NHARTS+3:4] = halted_i;
    end

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (idx)
            3'd0: begin
                rdata[1:0] = mode_reg;
                err = wr && (reg_req_i.wdata[1:0] == 2'd3 || busy);
            end
            3'd1: ;
            3'd2: rdata = status_word;
            3'd3: begin
                rdata[1:0] = active_mode_reg;
                err = wr;
            end
            3'd4: begin
                rdata[15:0] = switch_cnt_reg;
                err = wr;
            end
            default: err = 1'b1;
        endcase
    end

    assign reg_rsp_o.ready = reg_req_i.valid;
    assign reg_rsp_o.error = reg_req_i.valid & err;
    assign reg_rsp_o.rdata = rdata;

`ifdef SAFE_CSR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] to_cnt_reg;
    logic             timeout_reg;
    logic             clr_timeout;
    logic             limit_hit;

    assign clr_timeout  = wr && idx == 3'd2 && reg_req_i.wdata[2];
    assign limit_hit    = (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == HALT_REQ)
                to_cnt_reg <= '0;
            else if (state_reg == WAIT_HALT)
                to_cnt_reg <= to_cnt_reg + 1'b1;
            timeout_reg <= do_timeout | (timeout_reg & ~clr_timeout);
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        halt_req   = 1'b0;
        resume_o   = 1'b0;
        do_switch  = 1'b0;
        do_timeout = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = HALT_REQ;
            HALT_REQ: begin
                halt_req   = 1'b1;
                state_next = WAIT_HALT;
            end
            WAIT_HALT: begin
                halt_req = 1'b1;
                // A hart set that halts on the limit cycle still gets its switch.
                if (&halted_i) begin
                    state_next = SWITCH;
                end
`ifdef SAFE_CSR_TIMEOUT_EN
                else if (limit_hit) begin
                    do_timeout = 1'b1;
                    state_next = RESUME;
                end
`endif
            end
            SWITCH: begin
                halt_req   = 1'b1;
                do_switch  = 1'b1;
                state_next = RESUME;
            end
            RESUME: begin
                resume_o   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            mode_reg        <= 2'd0;
            active_mode_reg <= 2'd0;
            switch_cnt_reg  <= 16'd0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mode_we)
                mode_reg <= reg_req_i.wdata[1:0];
            if (do_switch) begin
                active_mode_reg <= mode_reg;
                if (switch_cnt_reg != 16'hFFFF)
                    switch_cnt_reg <= switch_cnt_reg + 16'd1;
            end
            done_reg <= do_switch | (done_reg & ~clr_done);
        end
    end

    generate
        for (genvar gi = 0; gi < NHARTS; gi++) begin : g_dbg
            assign debug_req_o[gi] = halt_req;
        end
    endgenerate

    assign active_mode_o = active_mode_reg;
    assign busy_o        = busy;

endmodule

// File: tb/tb_safe_wrapper_csr.sv
// Directed bench for safe_wrapper_csr: CSR responses go through a scoreboard queue, sequencing outputs are checked inline.
module tb_safe_wrapper_csr;
    import safe_wrapper_csr_pkg::*;

    localparam int NH = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    reg_req_t      req;
    reg_rsp_t      rsp;
    logic [NH-1:0] halted;
    logic [NH-1:0] debug_req;
    logic          resume;
    logic [1:0]    active_mode;
    logic          busy;

    safe_wrapper_csr #(
        .NHARTS(NH),
        .TIMEOUT_CYCLES(TO),
        .reg_req_t(reg_req_t),
        .reg_rsp_t(reg_rsp_t)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .reg_req_i(req),
        .reg_rsp_o(rsp),
        .halted_i(halted),
        .debug_req_o(debug_req),
        .resume_o(resume),
        .active_mode_o(active_mode),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   resume_cnt = 0;

    always @(posedge clk) begin
        if (resume === 1'b1) resume_cnt <= resume_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit chk_rd);
        exp_t e;
        exp_t p;
        req.addr  = a;
        req.write = w;
        req.wdata = d;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        p.tag = tag; p.rdata = er; p.err = ee; p.chk_rd = chk_rd;
        sb.push_back(p);
        @(negedge clk);
        e = sb.pop_front();
        $display("txn %s addr=%h we=%0d wdata=%h rdata=%h err=%0d", e.tag, a, w, d, rsp.rdata, rsp.error);
        check({e.tag, "_ready"}, 32'(rsp.ready), 32'd1);
        check({e.tag, "_err"}, 32'(rsp.error), 32'(e.err));
        if (e.chk_rd) check({e.tag, "_rdata"}, rsp.rdata, e.rdata);
        tick();
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic wait_resume(input string tag, input int exp_cycles);
        int n = 0;
        while (resume !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        halted = '0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_dbg", 32'(debug_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resume", 32'(resume), 32'd0);
        check("rst_active", 32'(active_mode), 32'd0);
        csr("rd_mode0", 32'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        csr("rd_status0", 32'h08, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        csr("rd_active0", 32'h0C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        csr("rd_cnt0", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Switch to TMR, harts halt two cycles after the request
        csr("wr_mode2", 32'h00, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        csr("start1", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        check("s1_dbg_halt_req", 32'(debug_req), 32'h7);
        check("s1_busy", 32'(busy), 32'd1);
        tick();
        check("s1_dbg_wait", 32'(debug_req), 32'h7);
        tick();
        halted = 3'b111;
        wait_resume("s1", 2);
        check("s1_active", 32'(active_mode), 32'd2);
        check("s1_dbg_resume", 32'(debug_req), 32'd0);
        tick();
        check("s1_busy_idle", 32'(busy), 32'd0);
        check("s1_resume_cnt", 32'(resume_cnt), 32'd1);
        halted = 3'b000;
        csr("rd_cnt1", 32'h10, 1'b0, 32'h0, 32'h1, 1'b0, 1'b1);
        csr("rd_status1", 32'h08, 1'b0, 32'h0, 32'h2, 1'b0, 1'b1);

        // Harts already halted: minimum latency, same mode still counts
        halted = 3'b111;
        csr("start2", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        wait_resume("s2", 3);
        tick();
        check("s2_busy_idle", 32'(busy), 32'd0);
        check("s2_resume_cnt", 32'(resume_cnt), 32'd2);
        halted = 3'b000;
        csr("rd_cnt2", 32'h10, 1'b0, 32'h0, 32'h2, 1'b0, 1'b1);

        // Error responses
        csr("wr_mode3", 32'h00, 1'b1, 32'h3, 32'h0, 1'b1, 1'b0);
        csr("rd_mode_kept", 32'h00, 1'b0, 32'h0, 32'h2, 1'b0, 1'b1);
        csr("rd_0x14", 32'h14, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        csr("wr_active_ro", 32'h0C, 1'b1, 32'h1, 32'h0, 1'b1, 1'b0);
        csr("wr_cnt_ro", 32'h10, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        csr("rd_active_kept", 32'h0C, 1'b0, 32'h0, 32'h2, 1'b0, 1'b1);
        csr("w1c_done", 32'h08, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        csr("rd_status_clr", 32'h08, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Writes during WAIT_HALT are refused
        csr("wr_mode1", 32'h00, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        csr("start3", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        tick();
        csr("wr_mode_busy", 32'h00, 1'b1, 32'h2, 32'h0, 1'b1, 1'b0);
        csr("start_busy", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        csr("rd_status_busy", 32'h08, 1'b0, 32'h0, 32'h1, 1'b0, 1'b1);
        halted = 3'b111;
        wait_resume("s3", 2);
        check("s3_active", 32'(active_mode), 32'd1);
        tick(); tick(); tick();
        check("s3_no_restart", 32'(busy), 32'd0);
        check("s3_resume_cnt", 32'(resume_cnt), 32'd3);
        halted = 3'b000;
        csr("rd_mode_s3", 32'h00, 1'b0, 32'h0, 32'h1, 1'b0, 1'b1);
        csr("rd_cnt3", 32'h10, 1'b0, 32'h0, 32'h3, 1'b0, 1'b1);

        // Reset while waiting for halt
        csr("wr_mode2b", 32'h00, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        csr("start4", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("mid_rst_dbg", 32'(debug_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_active", 32'(active_mode), 32'd0);
        check("mid_rst_resume", 32'(resume), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("mid_rst_resume_cnt", 32'(resume_cnt), 32'd3);
        csr("rd_mode_rst", 32'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        csr("rd_cnt_rst", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

`ifdef SAFE_CSR_TIMEOUT_EN
        // Two of three harts halt: abort after TO cycles in WAIT_HALT
        halted = 3'b011;
        csr("wr_mode_to", 32'h00, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        csr("start_to", 32'h04, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        wait_resume("to", TO + 1);
        check("to_active", 32'(active_mode), 32'd0);
        tick();
        check("to_busy_idle", 32'(busy), 32'd0);
        check("to_resume_cnt", 32'(resume_cnt), 32'd4);
        csr("rd_status_to", 32'h08, 1'b0, 32'h0, 32'h34, 1'b0, 1'b1);
        csr("rd_cnt_to", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        csr("w1c_to", 32'h08, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0);
        csr("rd_status_to_clr", 32'h08, 1'b0, 32'h0, 32'h30, 1'b0, 1'b1);
`else
        halted = 3'b011;
        csr("w1c_to_none", 32'h08, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0);
        csr("rd_status_snap", 32'h08, 1'b0, 32'h0, 32'h30, 1'b0, 1'b1);
`endif
        halted = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
